// File: rtl/rat_uart_tx_port_if.sv
// MCU output-bus view of the UART transmit port: port address, write data,
// write strobe, and the status byte returned toward the IN_PORT mux.
interface rat_uart_tx_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] STATUS_OUT;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input  STATUS_OUT);
  modport slave  (input  PORT_ID, OUT_PORT, IO_STRB, output STATUS_OUT);
endinterface

// File: rtl/rat_uart_tx_port.sv
// RAT MCU memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Optional transmit-done interrupt is enabled by defining RAT_UART_TX_INTR_EN.
module rat_uart_tx_port #(
  parameter logic [7:0] DATA_PORT_ID   = 8'h40,
  parameter logic [7:0] STATUS_PORT_ID = 8'h41,
  parameter int         CLKS_PER_BIT   = 868,
  parameter int         FIFO_DEPTH     = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  rat_uart_tx_port_if.slave  bus,
  output logic               TX,
  output logic               TX_BUSY,
  output logic               TX_INTR
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic full, empty, data_wr, status_wr, push, pop;

  // Pointers carry one extra wrap bit so equal indices distinguish full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_wr   = bus.IO_STRB && (bus.PORT_ID == DATA_PORT_ID);
  assign status_wr = bus.IO_STRB && (bus.PORT_ID == STATUS_PORT_ID);
  assign push      = data_wr && !full;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q;
    if (data_wr && full)                  ovf_d = 1'b1;
    else if (status_wr && bus.OUT_PORT[3]) ovf_d = 1'b0;
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.OUT_PORT;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == 16'd0) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            baud_d  = BAUD_RELOAD;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign TX             = tx_q;
  assign TX_BUSY        = (state_q != S_IDLE);
  assign bus.STATUS_OUT = {4'b0000, ovf_q, TX_BUSY, empty, full};

`ifdef RAT_UART_TX_INTR_EN
  logic intr_q, intr_d;
  assign intr_d = (state_q == S_STOP) && (state_d == S_IDLE);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) intr_q <= 1'b0;
    else          intr_q <= intr_d;
  end
  assign TX_INTR = intr_q;
`else
  assign TX_INTR = 1'b0;
`endif

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Self-checking bench for rat_uart_tx_port: frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_rat_uart_tx_port;
  localparam int CPB = 4;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx, tx_busy, tx_intr;

  rat_uart_tx_port_if bus_if ();

  rat_uart_tx_port #(
    .DATA_PORT_ID  (8'h40),
    .STATUS_PORT_ID(8'h41),
    .CLKS_PER_BIT  (CPB),
    .FIFO_DEPTH    (FD)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus_if.slave),
    .TX     (tx),
    .TX_BUSY(tx_busy),
    .TX_INTR(tx_intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: queue of pending bytes, one frame in flight identified by
  // its start cycle; line level follows from the elapsed time since that start.
  logic [7:0] mq[$];
  logic [7:0] m_frame = 8'h00;
  bit         m_busy  = 1'b0;
  bit         m_ovf   = 1'b0;
  bit         m_intr  = 1'b0;
  int         cyc     = 0;
  int         m_start = 0;
  int         m_len;
  bit         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0; m_ovf = 1'b0; m_intr = 1'b0; cyc = 0; m_start = 0;
    end else begin
      m_len  = mq.size();
      cyc    = cyc + 1;
      m_intr = 1'b0;
      m_done = m_busy && (cyc - m_start == 10 * CPB);
      if ((!m_busy || m_done) && m_len > 0) begin
        m_frame = mq.pop_front();
        m_start = cyc;
        m_busy  = 1'b1;
      end else if (m_done) begin
        m_busy = 1'b0;
        m_intr = 1'b1;
      end
      if (bus_if.IO_STRB && bus_if.PORT_ID == 8'h40) begin
        if (m_len == FD) m_ovf = 1'b1;
        else             mq.push_back(bus_if.OUT_PORT);
      end
      if (bus_if.IO_STRB && bus_if.PORT_ID == 8'h41 && bus_if.OUT_PORT[3]) m_ovf = 1'b0;
    end
  end

  bit         cmp_en = 1'b0;
  logic [9:0] exp_fr;
  logic       exp_tx;
  logic [7:0] exp_st;
  logic       exp_intr;

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_fr = {1'b1, m_frame, 1'b0};
      exp_tx = m_busy ? exp_fr[(cyc - m_start) / CPB] : 1'b1;
      exp_st = {4'b0000, m_ovf, m_busy, mq.size() == 0, mq.size() == FD};
`ifdef RAT_UART_TX_INTR_EN
      exp_intr = m_intr;
`else
      exp_intr = 1'b0;
`endif
      check("model_tx",     int'(tx),                exp_tx);
      check("model_busy",   int'(tx_busy),           int'(m_busy));
      check("model_status", int'(bus_if.STATUS_OUT), int'(exp_st));
      check("model_intr",   int'(tx_intr),           int'(exp_intr));
    end
  end

  // Line receiver: samples mid-bit after a falling edge, only while enabled.
  bit         rx_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rx_en && tx == 1'b0) begin
        repeat (2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  // Drives one bus cycle starting at a falling edge; returns after the capturing edge.
  task automatic drive(input logic [7:0] pid, input logic [7:0] data, input logic strb);
    bus_if.PORT_ID  = pid;
    bus_if.OUT_PORT = data;
    bus_if.IO_STRB  = strb;
    @(negedge clk);
    bus_if.IO_STRB  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    check(name, int'(tx_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [9:0] frame_a5;
  int         cnt, pulses, at;

  initial begin
    bus_if.PORT_ID  = 8'h00;
    bus_if.OUT_PORT = 8'h00;
    bus_if.IO_STRB  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx",     int'(tx),                1);
    check("rst_status", int'(bus_if.STATUS_OUT), 8'h02);
    check("rst_busy",   int'(tx_busy),           0);
    check("rst_intr",   int'(tx_intr),           0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte A5: start, LSB-first data, stop, each 4 clocks.
    frame_a5 = 10'b1101001010;
    drive(8'h40, 8'hA5, 1'b1);
    check("t1_pre_tx",     int'(tx),                1);
    check("t1_pre_status", int'(bus_if.STATUS_OUT), 8'h00);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("t1_frame_bit", int'(tx), int'(frame_a5[j / CPB]));
      if (j == 0)  check("t1_status_busy", int'(bus_if.STATUS_OUT), 8'h06);
      if (j == 39) check("t1_busy_k40",    int'(tx_busy),           1);
    end
    @(negedge clk);
    check("t1_busy_k41",   int'(tx_busy),           0);
    check("t1_status_end", int'(bus_if.STATUS_OUT), 8'h02);
    repeat (3) @(negedge clk);

    // Back-to-back bytes: no idle gap, 80 busy clocks in total.
    drive(8'h40, 8'h01, 1'b1);
    drive(8'h40, 8'h02, 1'b1);
    cnt = int'(tx_busy);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
      cnt++;
    end
    check("t2_busy_clocks", cnt, 80);
    repeat (3) @(negedge clk);

    // Overflow: six writes, sixth dropped, then OVF cleared via the status port.
    rx_q.delete();
    rx_en = 1'b1;
    for (int i = 0; i < 6; i++) drive(8'h40, 8'h10 + 8'(i), 1'b1);
    check("t3_status_ovf", int'(bus_if.STATUS_OUT), 8'h0D);
    drive(8'h41, 8'h08, 1'b1);
    check("t3_status_clr", int'(bus_if.STATUS_OUT), 8'h05);
    wait_idle("t3_drain", 400);
    repeat (4) @(negedge clk);
    rx_en = 1'b0;
    check("t3_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check("t3_rx_byte", int'(rx_q[i]), 8'h10 + i);

    // Ignored accesses: strobe low on the data port, strobe high on an unmapped port.
    drive(8'h40, 8'h77, 1'b0);
    drive(8'h42, 8'h66, 1'b1);
    check("t4_status", int'(bus_if.STATUS_OUT), 8'h02);
    check("t4_tx",     int'(tx),                1);
    repeat (10) @(negedge clk);
    check("t4_status_later", int'(bus_if.STATUS_OUT), 8'h02);

    // Reset mid-DATA of an FF frame with two bytes queued.
    drive(8'h40, 8'hFF, 1'b1);
    drive(8'h40, 8'hAA, 1'b1);
    drive(8'h40, 8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_busy_before", int'(tx_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_tx",     int'(tx),                1);
    check("t5_async_status", int'(bus_if.STATUS_OUT), 8'h02);
    check("t5_async_busy",   int'(tx_busy),           0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx == 1'b0) cnt++;
    end
    check("t5_tx_low_after", cnt, 0);
    check("t5_status_after", int'(bus_if.STATUS_OUT), 8'h02);

    // Interrupt pulse on the STOP-to-IDLE edge.
    drive(8'h40, 8'h3C, 1'b1);
    pulses = 0;
    at     = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (tx_intr) begin
        pulses++;
        at = i;
      end
    end
`ifdef RAT_UART_TX_INTR_EN
    check("t6_intr_pulses", pulses, 1);
    check("t6_intr_edge",   at,     41);
`else
    check("t6_intr_pulses", pulses, 0);
    check("t6_intr_edge",   at,     0);
`endif

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
